// File: rtl/avmm_pkg.sv
// Shared state encoding and helpers for the Avalon-MM command master.
package avmm_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StRd,
        StRdWait,
        StRsp
    } avmm_state_e;

    // States in which a bus transfer is in flight and the watchdog runs.
    function automatic logic is_bus_state(input avmm_state_e s);
        return (s == StWr) || (s == StRd) || (s == StRdWait);
    endfunction

endpackage

// File: rtl/avmm_watchdog.sv
// Saturating cycle counter that flags the last cycle a bus state may take.
module avmm_watchdog #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] Limit = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CntW-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Expires in the cycle whose increment brings the count to TIMEOUT.
    assign o_expired = (TIMEOUT != 0) && i_enable && (r_count >= Limit);

endmodule

// File: rtl/avmm_cmd_master.sv
// Avalon-MM master turning a valid/ready command stream into single bus transfers.
module avmm_cmd_master
    import avmm_pkg::*;
#(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned USE_RDV = 0,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_write,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [DATA_W-1:0] i_cmd_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err,
    output logic [ADDR_W-1:0] o_avm_address,
    output logic              o_avm_read,
    output logic              o_avm_write,
    output logic [DATA_W-1:0] o_avm_writedata,
    input  logic [DATA_W-1:0] i_avm_readdata,
    input  logic              i_avm_waitrequest,
    input  logic              i_avm_readdatavalid
);

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              err;
    } rsp_t;

    avmm_state_e r_state;
    cmd_t        r_cmd;
    rsp_t        r_rsp;
    logic        r_cmd_ready;
    logic        r_rsp_valid;
    logic        r_avm_read;
    logic        r_avm_write;

    logic w_cmd_fire;
    logic w_wd_enable;
    logic w_wd_expired;

    assign w_cmd_fire  = i_cmd_valid && r_cmd_ready;
    assign w_wd_enable = is_bus_state(r_state);

    avmm_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (w_cmd_fire),
        .i_enable (w_wd_enable),
        .o_expired(w_wd_expired)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_cmd       <= '0;
            r_rsp       <= '0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_avm_read  <= 1'b0;
            r_avm_write <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_cmd_ready <= !w_cmd_fire;
                    if (w_cmd_fire) begin
                        r_cmd.write <= i_cmd_write;
                        r_cmd.addr  <= i_cmd_addr;
                        r_cmd.wdata <= i_cmd_wdata;
                        r_avm_write <= i_cmd_write;
                        r_avm_read  <= !i_cmd_write;
                        r_state     <= i_cmd_write ? StWr : StRd;
                    end
                end
                // A transfer completing in the watchdog's last cycle still counts as done.
                StWr: begin
                    if (!i_avm_waitrequest || w_wd_expired) begin
                        r_avm_write <= 1'b0;
                        r_rsp.rdata <= '0;
                        r_rsp.err   <= i_avm_waitrequest;
                        r_rsp_valid <= 1'b1;
                        r_state     <= StRsp;
                    end
                end
                StRd: begin
                    if (!i_avm_waitrequest) begin
                        r_avm_read <= 1'b0;
                        if ((USE_RDV == 0) || i_avm_readdatavalid) begin
                            r_rsp.rdata <= i_avm_readdata;
                            r_rsp.err   <= 1'b0;
                            r_rsp_valid <= 1'b1;
                            r_state     <= StRsp;
                        end else begin
                            r_state <= StRdWait;
                        end
                    end else if (w_wd_expired) begin
                        r_avm_read  <= 1'b0;
                        r_rsp.rdata <= '0;
                        r_rsp.err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= StRsp;
                    end
                end
                StRdWait: begin
                    if (i_avm_readdatavalid || w_wd_expired) begin
                        r_rsp.rdata <= i_avm_readdatavalid ? i_avm_readdata : '0;
                        r_rsp.err   <= !i_avm_readdatavalid;
                        r_rsp_valid <= 1'b1;
                        r_state     <= StRsp;
                    end
                end
                StRsp: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_cmd_ready     = r_cmd_ready;
    assign o_rsp_valid     = r_rsp_valid;
    assign o_rsp_rdata     = r_rsp.rdata;
    assign o_rsp_err       = r_rsp.err;
    assign o_avm_address   = r_cmd.addr;
    assign o_avm_read      = r_avm_read;
    assign o_avm_write     = r_avm_write;
    assign o_avm_writedata = r_cmd.wdata;

endmodule

// File: tb/tb_avmm_cmd_master.sv
// Bench for avmm_cmd_master: instance 0 zero-latency reads, instance 1 readdatavalid reads.
module tb_avmm_cmd_master;

    localparam int T = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic [1:0]       cmd_valid, cmd_ready, cmd_write, rsp_valid, rsp_ready, rsp_err;
    logic [1:0][3:0]  cmd_addr, avm_address;
    logic [1:0][31:0] cmd_wdata, rsp_rdata, avm_writedata, avm_readdata;
    logic [1:0]       avm_read, avm_write, avm_waitrequest, avm_readdatavalid;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    avmm_cmd_master #(.ADDR_W(4), .DATA_W(32), .USE_RDV(0), .TIMEOUT(T)) u_dut0 (
        .i_clk(clk), .i_reset(reset),
        .i_cmd_valid(cmd_valid[0]), .o_cmd_ready(cmd_ready[0]), .i_cmd_write(cmd_write[0]),
        .i_cmd_addr(cmd_addr[0]), .i_cmd_wdata(cmd_wdata[0]),
        .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]), .o_rsp_rdata(rsp_rdata[0]),
        .o_rsp_err(rsp_err[0]), .o_avm_address(avm_address[0]), .o_avm_read(avm_read[0]),
        .o_avm_write(avm_write[0]), .o_avm_writedata(avm_writedata[0]),
        .i_avm_readdata(avm_readdata[0]), .i_avm_waitrequest(avm_waitrequest[0]),
        .i_avm_readdatavalid(avm_readdatavalid[0])
    );

    avmm_cmd_master #(.ADDR_W(4), .DATA_W(32), .USE_RDV(1), .TIMEOUT(T)) u_dut1 (
        .i_clk(clk), .i_reset(reset),
        .i_cmd_valid(cmd_valid[1]), .o_cmd_ready(cmd_ready[1]), .i_cmd_write(cmd_write[1]),
        .i_cmd_addr(cmd_addr[1]), .i_cmd_wdata(cmd_wdata[1]),
        .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]), .o_rsp_rdata(rsp_rdata[1]),
        .o_rsp_err(rsp_err[1]), .o_avm_address(avm_address[1]), .o_avm_read(avm_read[1]),
        .o_avm_write(avm_write[1]), .o_avm_writedata(avm_writedata[1]),
        .i_avm_readdata(avm_readdata[1]), .i_avm_waitrequest(avm_waitrequest[1]),
        .i_avm_readdatavalid(avm_readdatavalid[1])
    );

    typedef struct {
        int          k;
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] wd;
        int          waits;
        int          rdv_dly;
        logic [31:0] rd;
        int          exp_strobes;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave model plus response collection for one transaction on instance k.
    task automatic run_txn(input int k, input logic wr, input logic [3:0] addr,
                           input logic [31:0] wd, input int waits, input int rdv_dly,
                           input logic [31:0] rd, input int rsp_dly,
                           output int strobes, output logic [31:0] rdata, output logic err,
                           output logic got, output logic bus_ok);
        int acc;
        strobes = 0; acc = -1; got = 1'b0; bus_ok = 1'b1; rdata = '0; err = 1'b0;
        for (int i = 0; i < 5 && !cmd_ready[k]; i++) @(negedge clk);
        cmd_valid[k] = 1'b1; cmd_write[k] = wr; cmd_addr[k] = addr; cmd_wdata[k] = wd;
        avm_waitrequest[k] = 1'b1;
        @(negedge clk);
        cmd_valid[k] = 1'b0; cmd_addr[k] = 4'($urandom); cmd_wdata[k] = $urandom;
        for (int c = 0; c < 40; c++) begin
            if (rsp_valid[k]) break;
            if (avm_read[k] || avm_write[k]) begin
                strobes++;
                if (avm_address[k] !== addr || (avm_read[k] && avm_write[k]) ||
                    avm_read[k] == wr || (wr && avm_writedata[k] !== wd)) bus_ok = 1'b0;
                avm_waitrequest[k] = (strobes <= waits);
                if (!avm_waitrequest[k] && !wr) acc = c;
            end
            avm_readdatavalid[k] = (k == 1) && (acc >= 0) && (c == acc + rdv_dly);
            avm_readdata[k] = (((k == 0) && (acc == c)) || avm_readdatavalid[k]) ?
                              rd : 32'hDEAD_BEEF;
            @(negedge clk);
        end
        avm_readdatavalid[k] = 1'b0;
        avm_waitrequest[k] = 1'b0;
        if (rsp_valid[k]) begin
            got = 1'b1; rdata = rsp_rdata[k]; err = rsp_err[k];
            for (int i = 0; i < rsp_dly; i++) begin
                if (!rsp_valid[k] || rsp_rdata[k] !== rdata || rsp_err[k] !== err ||
                    cmd_ready[k] || avm_read[k] || avm_write[k]) bus_ok = 1'b0;
                @(negedge clk);
            end
            rsp_ready[k] = 1'b1;
            @(negedge clk);
            rsp_ready[k] = 1'b0;
            if (rsp_valid[k] || !cmd_ready[k]) bus_ok = 1'b0;
        end
    endtask

    // Reference outcome from bus-cycle arithmetic: the transfer gets T cycles in bus states.
    function automatic void model(input int k, input logic wr, input int waits,
                                  input int rdv_dly, input logic [31:0] rd, output int strobes,
                                  output logic [31:0] rdata, output logic err);
        int accept_cycle;
        accept_cycle = waits + 1;
        if (accept_cycle > T) begin
            strobes = T; rdata = '0; err = 1'b1;
        end else begin
            strobes = accept_cycle;
            if (wr) begin
                rdata = '0; err = 1'b0;
            end else if (k == 0 || accept_cycle + rdv_dly <= T) begin
                rdata = rd; err = 1'b0;
            end else begin
                rdata = '0; err = 1'b1;
            end
        end
    endfunction

    task automatic check_txn(input string tag, input int s, input logic [31:0] r, input logic e,
                             input logic g, input logic ok, input int es,
                             input logic [31:0] er, input logic ee);
        check({tag, " got_rsp"}, 64'(g), 64'd1);
        check({tag, " strobe_cycles"}, 64'(s), 64'(es));
        check({tag, " rsp_rdata"}, 64'(r), 64'(er));
        check({tag, " rsp_err"}, 64'(e), 64'(ee));
        check({tag, " bus_protocol"}, 64'(ok), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        int s, waits, rdv, rdly, k;
        logic [31:0] r, er, wd, rd;
        logic e, g, ok, ee, wr;
        logic [3:0] addr;
        int es;

        cmd_valid = '0; cmd_write = '0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = '0;
        avm_readdata = '0; avm_waitrequest = '0; avm_readdatavalid = '0;

        tbl[0] = '{0, 1'b1, 4'h0, 32'hA5A5_0001, 0,  0,  32'h0,         1, 32'h0,         1'b0};
        tbl[1] = '{0, 1'b0, 4'h3, 32'h0,         3,  0,  32'h0000_00FF, 4, 32'h0000_00FF, 1'b0};
        tbl[2] = '{1, 1'b0, 4'h5, 32'h0,         0,  5,  32'h1234_5678, 1, 32'h1234_5678, 1'b0};
        tbl[3] = '{0, 1'b1, 4'hF, 32'h5555_AAAA, 20, 0,  32'h0,         8, 32'h0,         1'b1};
        tbl[4] = '{0, 1'b0, 4'h2, 32'h0,         20, 0,  32'h0000_0077, 8, 32'h0,         1'b1};
        tbl[5] = '{1, 1'b0, 4'h1, 32'h0,         2,  0,  32'hCAFE_F00D, 3, 32'hCAFE_F00D, 1'b0};
        tbl[6] = '{1, 1'b0, 4'h9, 32'h0,         0,  20, 32'h0BAD_0BAD, 1, 32'h0,         1'b1};
        tbl[7] = '{1, 1'b1, 4'h4, 32'hFEED_0004, 6,  0,  32'h0,         7, 32'h0,         1'b0};
        tbl[8] = '{1, 1'b0, 4'hA, 32'h0,         0,  7,  32'h7777_0007, 1, 32'h7777_0007, 1'b0};

        // Reset state.
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset cmd_ready[%0d]", i), 64'(cmd_ready[i]), 64'd0);
            check($sformatf("reset rsp_valid[%0d]", i), 64'(rsp_valid[i]), 64'd0);
            check($sformatf("reset strobes[%0d]", i), 64'({avm_read[i], avm_write[i]}), 64'd0);
            check($sformatf("reset address[%0d]", i), 64'(avm_address[i]), 64'd0);
            check($sformatf("reset writedata[%0d]", i), 64'(avm_writedata[i]), 64'd0);
            check($sformatf("reset rsp_fields[%0d]", i), 64'({rsp_rdata[i], rsp_err[i]}), 64'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        check("post_reset cmd_ready", 64'(cmd_ready), 64'b11);

        foreach (tbl[i]) begin
            run_txn(tbl[i].k, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].waits, tbl[i].rdv_dly,
                    tbl[i].rd, 0, s, r, e, g, ok);
            check_txn($sformatf("vec%0d", i), s, r, e, g, ok,
                      tbl[i].exp_strobes, tbl[i].exp_rdata, tbl[i].exp_err);
        end

        // Late readdatavalid after a timed-out read must not create a response.
        run_txn(1, 1'b0, 4'h6, 32'h0, 0, 30, 32'h1111_2222, 0, s, r, e, g, ok);
        check_txn("late_rdv_abort", s, r, e, g, ok, 1, 32'h0, 1'b1);
        avm_readdatavalid[1] = 1'b1; avm_readdata[1] = 32'h1111_2222;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("late_rdv rsp_valid", 64'(rsp_valid[1]), 64'd0);
        end
        avm_readdatavalid[1] = 1'b0;
        check("late_rdv cmd_ready", 64'(cmd_ready[1]), 64'd1);

        // Backpressure: response held, a waiting command is taken only after the handshake.
        cmd_valid[0] = 1'b1; cmd_write[0] = 1'b1; cmd_addr[0] = 4'h6; cmd_wdata[0] = 32'h1111_2222;
        @(negedge clk);
        cmd_addr[0] = 4'h7; cmd_wdata[0] = 32'h3333_4444;
        check("bp avm_write", 64'(avm_write[0]), 64'd1);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check("bp hold", 64'({rsp_valid[0], rsp_err[0], cmd_ready[0], avm_write[0]}), 64'b1000);
            check("bp rsp_rdata", 64'(rsp_rdata[0]), 64'd0);
            check("bp bus_regs", 64'({avm_address[0], avm_writedata[0]}), {28'd0, 4'h6, 32'h1111_2222});
            @(negedge clk);
        end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        rsp_ready[0] = 1'b0;
        check("bp after_hs", 64'({cmd_ready[0], rsp_valid[0], avm_write[0]}), 64'b100);
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        check("bp next_cmd", 64'({avm_write[0], avm_address[0], avm_writedata[0]}),
              {27'd0, 1'b1, 4'h7, 32'h3333_4444});
        @(negedge clk);
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        rsp_ready[0] = 1'b0;

        // Randomized transactions against the reference model.
        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(0, 1); wr = 1'($urandom_range(0, 1)); addr = 4'($urandom);
            wd = $urandom; rd = $urandom; waits = $urandom_range(0, 10);
            rdv = $urandom_range(0, 9); rdly = $urandom_range(0, 3);
            if (k == 1 && waits + 1 == T) rdv = 0;
            model(k, wr, waits, rdv, rd, es, er, ee);
            run_txn(k, wr, addr, wd, waits, rdv, rd, rdly, s, r, e, g, ok);
            check_txn($sformatf("rand%0d", n), s, r, e, g, ok, es, er, ee);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Asynchronous reset in the middle of a stalled write.
        avm_waitrequest[0] = 1'b1;
        cmd_valid[0] = 1'b1; cmd_write[0] = 1'b1; cmd_addr[0] = 4'hC; cmd_wdata[0] = 32'h0C0C_0C0C;
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        check("arst write_active", 64'(avm_write[0]), 64'd1);
        #2 reset = 1'b1;
        #1 check("arst write_dropped", 64'(avm_write[0]), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        avm_waitrequest[0] = 1'b0;
        @(negedge clk);
        check("arst release", 64'({cmd_ready[0], rsp_valid[0], avm_write[0], avm_read[0]}),
              64'b1000);
        repeat (2) @(negedge clk);
        check("arst no_rsp", 64'(rsp_valid[0]), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/avmm_cmd_master.md
Name: avmm_cmd_master

Overview:
- Avalon-MM master (initiator) that drives memory-mapped slaves such as the LED/GPIO register blocks from a simple valid/ready command stream.
- Sits between an on-fabric sequencer (button/test logic) and the slave's avs_s0 port.
- One transaction outstanding at a time; supports waitrequest, optional readdatavalid, and a watchdog timeout that reports errors instead of hanging.

Parameters:
- ADDR_W, 4, Avalon address width (word address).
- DATA_W, 32, data width of writedata/readdata.
- USE_RDV, 0, 0 = read data captured in the cycle read is accepted (zero-latency slave); 1 = wait for readdatavalid.
- TIMEOUT, 1023, max cycles spent in any bus state before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target word address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  DATA_W  read data (0 for writes and errors).
- rsp_err  out  1  1 = transaction aborted by timeout.
- avm_address  out  ADDR_W  Avalon address.
- avm_read  out  1  Avalon read strobe.
- avm_write  out  1  Avalon write strobe.
- avm_writedata  out  DATA_W  Avalon write data.
- avm_readdata  in  DATA_W  Avalon read data.
- avm_waitrequest  in  1  slave stall; tie 0 for slaves without it.
- avm_readdatavalid  in  1  used only when USE_RDV=1.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0 (cmd_ready=0 in reset, 1 in IDLE thereafter); address/writedata registers 0; timeout counter 0.
- States: IDLE, WR, RD, RD_WAIT, RSP.
- IDLE:
  - cmd_ready=1.
  - On handshake: latch addr/wdata/write flag, clear counter, go to WR or RD.
  - avm_* strobes are asserted from the next cycle (registered outputs).
- WR:
  - avm_write=1, with address/writedata stable.
  - First cycle with waitrequest=0 → RSP with rsp_rdata=0, rsp_err=0.
- RD:
  - avm_read=1.
  - On waitrequest=0: if USE_RDV=0, capture avm_readdata that cycle → RSP; if USE_RDV=1 → RD_WAIT.
- RD_WAIT:
  - avm_read=0; wait for readdatavalid, then capture readdata → RSP.
  - readdatavalid in the same cycle the read is accepted (RD state, USE_RDV=1) is also captured and goes straight to RSP.
- RSP:
  - rsp_valid=1; rsp_* held stable until rsp_ready; then → IDLE.
  - cmd_ready=0 throughout.
  - Minimum command-to-command spacing is 3 cycles with zero-wait slave and rsp_ready=1.
- Timeout:
  - Counter increments each cycle in WR/RD/RD_WAIT.
  - When counter == TIMEOUT (TIMEOUT≠0): deassert strobes, → RSP with rsp_err=1, rsp_rdata=0.
  - Late readdatavalid after abort is ignored in RSP/IDLE.
- avm_read and avm_write are never both 1; strobes are 0 in IDLE and RSP.
- avm_address and avm_writedata change only on command acceptance.
- Reset mid-transaction drops strobes immediately (async) and discards the pending response.
- cmd_valid while not ready is ignored; the command is not latched.

Decomposition:
- Package avmm_pkg: state enum (IDLE, WR, RD, RD_WAIT, RSP), command struct (write, addr, wdata), response struct (rdata, err).
- Sub-module avmm_watchdog: counter with clear/enable/expired, parameterised by TIMEOUT; everything else lives in one FSM.

Test Plan:
- Write, zero wait: cmd write addr 0 data 0xA5A5_0001 → avm_write high exactly 1 cycle with that addr/data; rsp_valid next cycle, err=0, rdata=0.
- Read, USE_RDV=0, waitrequest high 3 cycles, readdata=0x0000_00FF → avm_read high 4 cycles; rsp_rdata=0xFF, err=0.
- Read, USE_RDV=1, readdatavalid 5 cycles after acceptance with 0x1234_5678 → avm_read deasserted after accept; rsp_rdata=0x1234_5678.
- Timeout, TIMEOUT=8, waitrequest stuck high → strobe drops after 8 cycles; rsp_err=1, rdata=0; a later readdatavalid pulse produces no second response.
- Backpressure: rsp_ready low 10 cycles → rsp stable, cmd_ready=0; a new cmd_valid is not accepted until the cycle after rsp handshake.
- Async reset asserted mid-WR → avm_write falls without a clock edge; after release: IDLE, cmd_ready=1, no rsp_valid.
